// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The z/n/v flag signals exist only when PIPE_CLA_FLAGS_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
`ifdef PIPE_CLA_FLAGS_EN
  logic             z;
  logic             n;
  logic             v;
`endif

  modport master (
    output in_valid, x, y, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out
`ifdef PIPE_CLA_FLAGS_EN
    , input z, n, v
`endif
  );

  modport slave (
    input  in_valid, x, y, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out
`ifdef PIPE_CLA_FLAGS_EN
    , output z, n, v
`endif
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, GROUPS_PER_STAGE 4-bit groups per stage.
// Define PIPE_CLA_FLAGS_EN to build the registered z/n/v result flags.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned GROUPS_PER_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned SliceW  = 4 * GROUPS_PER_STAGE;
  localparam int unsigned NSTAGES = WIDTH / SliceW;

  logic [WIDTH-1:0]   b_eff;
  logic               c0;
  logic [NSTAGES-1:0] v_q, v_d, load, en, up_valid;

  assign b_eff = bus.sub ? ~bus.y : bus.y;
  assign c0    = bus.sub | bus.c_in;

  // A stage can load when empty or when everything downstream of it moves this cycle.
  always_comb begin
    logic down;
    down = bus.out_ready;
    for (int k = int'(NSTAGES) - 1; k >= 0; k--) begin
      down    = !v_q[k] || down;
      load[k] = down;
    end
  end

  assign up_valid = (v_q << 1) | NSTAGES'(bus.in_valid);
  assign en       = load & up_valid;
  assign v_d      = en | (~load & v_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int unsigned DoneW = SliceW * k;
    localparam int unsigned RemW  = WIDTH - DoneW - SliceW;

    logic [WIDTH-DoneW-1:0]  src_x, src_b;
    logic                    src_c;
    logic [SliceW-1:0]       sum_slice;
    logic                    carry;
    logic [DoneW+SliceW-1:0] sum_d, sum_q;
    logic                    c_q;

    if (k == 0) begin : g_src
      assign src_x = bus.x;
      assign src_b = b_eff;
      assign src_c = c0;
      assign sum_d = sum_slice;
    end else begin : g_src
      assign src_x = g_stage[k-1].g_rem.x_q;
      assign src_b = g_stage[k-1].g_rem.b_q;
      assign src_c = g_stage[k-1].c_q;
      assign sum_d = {sum_slice, g_stage[k-1].sum_q};
    end

    // Group g/p first, then group carries from the stage carry-in.
    always_comb begin
      logic [SliceW-1:0]         a, b, g, p;
      logic [GROUPS_PER_STAGE:0] gc;
      logic                      gg, gp, c;
      a         = src_x[SliceW-1:0];
      b         = src_b[SliceW-1:0];
      g         = a & b;
      p         = a ^ b;
      gc        = '0;
      gc[0]     = src_c;
      sum_slice = '0;
      for (int j = 0; j < int'(GROUPS_PER_STAGE); j++) begin
        gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
             ((&p[4*j+1 +: 3]) & g[4*j]);
        gp = &p[4*j +: 4];
        gc[j+1] = gg | (gp & gc[j]);
        c = gc[j];
        for (int i = 0; i < 4; i++) begin
          sum_slice[4*j+i] = p[4*j+i] ^ c;
          c = g[4*j+i] | (p[4*j+i] & c);
        end
      end
      carry = gc[GROUPS_PER_STAGE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (en[k]) begin
        sum_q <= sum_d;
        c_q   <= carry;
      end
    end

    if (RemW > 0) begin : g_rem
      logic [RemW-1:0] x_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          b_q <= '0;
        end else if (en[k]) begin
          x_q <= src_x[WIDTH-DoneW-1:SliceW];
          b_q <= src_b[WIDTH-DoneW-1:SliceW];
        end
      end
    end

`ifdef PIPE_CLA_FLAGS_EN
    if (k == NSTAGES - 1) begin : g_flags
      logic z_q, n_q, ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          z_q   <= 1'b0;
          n_q   <= 1'b0;
          ovf_q <= 1'b0;
        end else if (en[k]) begin
          z_q   <= (sum_d == '0);
          n_q   <= sum_slice[SliceW-1];
          ovf_q <= (src_x[SliceW-1] == src_b[SliceW-1]) &&
                   (sum_slice[SliceW-1] != src_x[SliceW-1]);
        end
      end
    end
`endif
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_q[NSTAGES-1];
  assign bus.s         = g_stage[NSTAGES-1].sum_q;
  assign bus.c_out     = g_stage[NSTAGES-1].c_q;
`ifdef PIPE_CLA_FLAGS_EN
  assign bus.z = g_stage[NSTAGES-1].g_flags.z_q;
  assign bus.n = g_stage[NSTAGES-1].g_flags.n_q;
  assign bus.v = g_stage[NSTAGES-1].g_flags.ovf_q;
`endif
endmodule
